// File: rtl/shift_pkg.sv
// Shared types for the shift command path: shift modes and the packed command word
// carried from the issue FIFO to barrel_shifter.
package shift_pkg;

    localparam int unsigned DSIZE_DEF = 64;
    localparam int unsigned ASIZE_DEF = 6;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ROL = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_t;

    typedef struct packed {
        shift_mode_t            mode;
        logic [ASIZE_DEF-1:0]   amount;
        logic [DSIZE_DEF-1:0]   data;
    } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and empty are distinct.
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  shift_cmd_t               wdata_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output shift_cmd_t               head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    shift_cmd_t  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level_o = wptr_q - rptr_q;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + PtrOne;
        if (do_pop)  rptr_d = rptr_q + PtrOne;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/shift_cmd_pipe.sv
// Issue stage ahead of barrel_shifter: buffers commands, drives the shifter from the FIFO head
// and registers the shifter output behind a valid/ready result port.
module shift_cmd_pipe
    import shift_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned ASIZE = ASIZE_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_mode,
    input  logic [ASIZE-1:0]         cmd_amount,
    input  logic [DSIZE-1:0]         cmd_data,
    output logic [DSIZE-1:0]         sh_in,
    output logic [ASIZE-1:0]         sh_amount,
    output logic [1:0]               sh_mode,
    input  logic [DSIZE-1:0]         sh_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DSIZE-1:0]         res_data,
    output logic [1:0]               res_mode,
    output logic [$clog2(DEPTH):0]   level
);

    logic        full, empty, push, adv;
    shift_cmd_t  wcmd, head;

    logic              res_valid_q, res_valid_d;
    logic [DSIZE-1:0]  res_data_q, res_data_d;
    shift_mode_t       res_mode_q, res_mode_d;

    assign wcmd = '{mode: shift_mode_t'(cmd_mode), amount: cmd_amount, data: cmd_data};

    // cmd_ready looks only at FIFO state, never at res_ready.
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign adv       = !empty && (!res_valid_q || res_ready);

    shift_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (wcmd),
        .pop_i   (adv),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level),
        .head_o  (head)
    );

    // An empty FIFO presents a no-op LSL by 0 to the shifter.
    assign sh_in     = empty ? '0 : head.data;
    assign sh_amount = empty ? '0 : head.amount;
    assign sh_mode   = empty ? SH_LSL : head.mode;

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_mode_d  = res_mode_q;
        if (adv) begin
            res_valid_d = 1'b1;
            res_data_d  = sh_out;
            res_mode_d  = head.mode;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_mode_q  <= SH_LSL;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_mode_q  <= res_mode_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_mode  = res_mode_q;

endmodule

// File: tb/tb_shift_cmd_pipe.sv
// Randomised bench for shift_cmd_pipe against a queue-based reference model, with a
// behavioural barrel_shifter closing the sh_* loop.
module tb_shift_cmd_pipe;

    localparam int unsigned DSIZE = 64;
    localparam int unsigned ASIZE = 6;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_mode = '0;
    logic [ASIZE-1:0] cmd_amount = '0;
    logic [DSIZE-1:0] cmd_data = '0;
    logic [DSIZE-1:0] sh_in;
    logic [ASIZE-1:0] sh_amount;
    logic [1:0]       sh_mode;
    logic [DSIZE-1:0] sh_out;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [DSIZE-1:0] res_data;
    logic [1:0]       res_mode;
    logic [LW-1:0]    level;

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_shift(logic [1:0] m, logic [5:0] a, logic [63:0] d);
        int unsigned n;
        n = a;
        case (m)
            2'b00:   return d << n;
            2'b01:   return d >> n;
            2'b10:   return (d << n) | (d >> (64 - n));
            default: return (d >> n) | (d << (64 - n));
        endcase
    endfunction

    assign sh_out = ref_shift(sh_mode, sh_amount, sh_in);

    shift_cmd_pipe #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_amount (cmd_amount),
        .cmd_data   (cmd_data),
        .sh_in      (sh_in),
        .sh_amount  (sh_amount),
        .sh_mode    (sh_mode),
        .sh_out     (sh_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_mode   (res_mode),
        .level      (level)
    );

    typedef struct {
        logic [1:0]  m;
        logic [5:0]  a;
        logic [63:0] d;
    } mcmd_t;

    mcmd_t       q[$];
    bit          m_rv = 1'b0;
    logic [63:0] m_rd = '0;
    logic [1:0]  m_rm = '0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic compare_all();
        check("cmd_ready", 64'(cmd_ready), 64'(q.size() < DEPTH));
        check("level", 64'(level), 64'(q.size()));
        check("res_valid", 64'(res_valid), 64'(m_rv));
        if (m_rv) begin
            check("res_data", res_data, m_rd);
            check("res_mode", 64'(res_mode), 64'(m_rm));
        end
        if (q.size() > 0) begin
            check("sh_in", sh_in, q[0].d);
            check("sh_amount", 64'(sh_amount), 64'(q[0].a));
            check("sh_mode", 64'(sh_mode), 64'(q[0].m));
        end else begin
            check("sh_in_idle", sh_in, 64'd0);
            check("sh_amount_idle", 64'(sh_amount), 64'd0);
            check("sh_mode_idle", 64'(sh_mode), 64'd0);
        end
    endtask

    // One clock: drive at negedge, update the model at posedge, compare at the next negedge.
    task automatic step(input bit v, input logic [1:0] m, input logic [5:0] a,
                        input logic [63:0] d, input bit rr);
        bit do_push, do_pop;
        cmd_valid  = v;
        cmd_mode   = m;
        cmd_amount = a;
        cmd_data   = d;
        res_ready  = rr;
        @(posedge clk);
        do_push = v && (q.size() < DEPTH);
        do_pop  = (q.size() > 0) && (!m_rv || rr);
        if (do_pop) begin
            m_rd = ref_shift(q[0].m, q[0].a, q[0].d);
            m_rm = q[0].m;
            m_rv = 1'b1;
            void'(q.pop_front());
        end else if (m_rv && rr) begin
            m_rv = 1'b0;
        end
        if (do_push) q.push_back('{m: m, a: a, d: d});
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 6'd0, 64'd0, rr);
    endtask

    task automatic model_reset();
        q.delete();
        m_rv = 1'b0;
        m_rd = '0;
        m_rm = '0;
    endtask

    initial begin
        #2;
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", res_data, 64'd0);
        check("rst_res_mode", 64'(res_mode), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compare_all();

        // Empty drive: nothing pushed, shifter sees zeros, no result appears.
        idle(10, 1'b1);

        // Single LSL, then ROL wrap and ROR.
        step(1'b1, 2'b00, 6'd4, 64'h1, 1'b0);
        idle(2, 1'b0);
        check("lsl_result", res_data, 64'h10);
        idle(1, 1'b1);
        step(1'b1, 2'b10, 6'd4, 64'hF000_0000_0000_0000, 1'b1);
        idle(1, 1'b0);
        check("rol_result", res_data, 64'hF);
        step(1'b1, 2'b11, 6'd8, 64'hFF, 1'b1);
        idle(1, 1'b0);
        check("ror_result", res_data, 64'hFF00_0000_0000_0000);
        idle(2, 1'b1);

        // Backpressure: six back-to-back pushes with the consumer stalled.
        for (int i = 0; i < 6; i++)
            step(1'b1, 2'(i), 6'(i + 1), 64'($urandom) << 8 | 64'(i), 1'b0);
        check("full_level", 64'(level), 64'(DEPTH));
        check("full_ready", 64'(cmd_ready), 64'd0);
        idle(8, 1'b1);

        // Streaming LSR.
        for (int i = 0; i < 16; i++)
            step(1'b1, 2'b01, 6'(i), 64'h8000_0000_0000_0000, 1'b1);
        idle(3, 1'b1);

        // Build level=3 with a held result, then reset between edges.
        for (int i = 0; i < 4; i++) step(1'b1, 2'b00, 6'(i), 64'($urandom), 1'b0);
        check("pre_rst_level", 64'(level), 64'd3);
        #2;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("mid_rst_res_valid", 64'(res_valid), 64'd0);
        check("mid_rst_res_data", res_data, 64'd0);
        check("mid_rst_level", 64'(level), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compare_all();
        step(1'b1, 2'b11, 6'd1, 64'h3, 1'b1);
        idle(1, 1'b0);
        check("post_rst_result", res_data, 64'h8000_0000_0000_0001);
        idle(4, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) < 60), 2'($urandom), 6'($urandom),
                 {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 99) < 55));
        idle(8, 1'b1);
        check("drained_level", 64'(level), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_cmd_pipe.md
Name: shift_cmd_pipe

Overview:
- Issue stage directly upstream of barrel_shifter.
- Accepts shift commands (mode, amount, data) over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents the FIFO head to barrel_shifter's combinational inputs, then captures its output into a registered result port with valid/ready.
- Decouples the producer from the consumer and gives the shifter path a registered boundary on both sides.

Parameters:
- DSIZE, 64, data width; must match barrel_shifter DSIZE.
- ASIZE, 6, shift-amount width; must match barrel_shifter ASIZE.
- DEPTH, 4, command FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state is rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_mode  in  2  00 LSL, 01 LSR, 10 ROL, 11 ROR.
- cmd_amount  in  ASIZE  shift amount.
- cmd_data  in  DSIZE  operand.
- sh_in  out  DSIZE  to barrel_shifter.in.
- sh_amount  out  ASIZE  to barrel_shifter.amount.
- sh_mode  out  2  to barrel_shifter.mode.
- sh_out  in  DSIZE  from barrel_shifter.out.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  consumer takes result.
- res_data  out  DSIZE  registered shift result.
- res_mode  out  2  mode of the command that produced res_data.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO pointers cleared; level=0.
  - res_valid=0, res_data=0, res_mode=0.
  - cmd_ready=1 once reset releases.
  - Reset mid-operation discards all queued and held commands; no partial result survives.
- Push: cmd_valid && cmd_ready at a rising edge writes {mode, amount, data} at the write pointer.
  - Write pointer wraps modulo DEPTH; an extra pointer bit distinguishes full from empty.
  - Producer must hold the command stable while cmd_valid && !cmd_ready.
- Shifter drive: sh_in/sh_amount/sh_mode are combinational from the FIFO head entry.
  - When empty, all three are driven 0, so the shifter sees a no-op LSL by 0.
- Advance condition: adv = !empty && (!res_valid || res_ready).
  - On adv: res_data<=sh_out, res_mode<=head mode, res_valid<=1, read pointer increments (pop).
  - If res_valid && res_ready && empty: res_valid<=0; res_data is held (don't-care).
  - If res_valid && !res_ready: result register and FIFO head are held unchanged (stall).
- Latency: a command accepted at edge N is at the head after N if the FIFO was empty. It appears on res_data with res_valid=1 after edge N+1. Minimum latency is 2 edges, with no combinational path from cmd_* to res_*.
- Throughput: one command per cycle sustained while res_ready=1.
- Full (level==DEPTH): cmd_ready=0. There is no push-through-pop when full; cmd_ready never depends on res_ready, so there is no combinational ready path.
- Empty with a push in the same cycle: the entry is written, and the pop is evaluated next cycle (no bypass).
- Simultaneous push and pop when not full: level is unchanged and both pointers advance.
- level: +1 on push-only, −1 on pop-only, unchanged otherwise; never exceeds DEPTH and never drops below 0.
- Ordering: results leave strictly in command order.

Decomposition:
- Package shift_pkg:
  - Mode constants SH_LSL=2'b00, SH_LSR=2'b01, SH_ROL=2'b10, SH_ROR=2'b11.
  - Packed command struct shift_cmd_t {mode, amount, data}, parameterised through package localparams DSIZE_DEF=64 and ASIZE_DEF=6.
- One sub-module: shift_cmd_fifo.
  - Synchronous FIFO for shift_cmd_t, with ports push, pop, full, empty, level, head.
  - Result register and advance logic live in the top.
- barrel_shifter is instantiated beside this block by the parent, not inside it.

Test Plan:
- Single LSL: reset, then push mode=00, amount=4, data=0x1 at edge N → res_valid=1 after edge N+1, res_data=0x10, res_mode=00.
- ROL wrap: push mode=10, amount=4, data=0xF000_0000_0000_0000 → res_data=0x0000_0000_0000_000F. ROR amount=8 of 0xFF → 0xFF00_0000_0000_0000.
- Backpressure/full: hold res_ready=0 and push 6 commands back-to-back.
  - After the first reaches res_data, the FIFO fills: level=4, cmd_ready=0, extra pushes are ignored.
  - Releasing res_ready drains results in order, one per cycle.
- Streaming: res_ready=1, push 16 commands on consecutive cycles (LSR amount=i of 0x8000_0000_0000_0000) → 16 consecutive res_valid cycles, res_data=0x8000_0000_0000_0000>>i, level stays ≤1.
- Reset mid-stream: with level=3 and res_valid=1, assert rst_n=0 asynchronously between edges.
  - Immediately: res_valid=0, res_data=0, level=0.
  - After release: a new push produces only its own result.
- Empty drive: after reset with no pushes, sh_in=0, sh_amount=0, sh_mode=0, and res_valid stays 0 for 10 cycles.
